cube_line_raster: RTL
=====================

Name: cube_line_raster

Overview:
Bresenham line rasteriser that walks one screen-space edge of the cube, from endpoint (x0,y0) to endpoint (x1,y1), and emits one pixel coordinate per accepted cycle. It sits directly upstream of the cube face-fill/colouring stage. That stage uses the emitted per-row edge x-positions, and the pixel count, as face boundaries. Coordinates share the display's Xpos/Ypos widths: 11-bit X, 10-bit Y. The block handles all eight octants and stalls on downstream backpressure.

Parameters:
XW, 11, X coordinate width (matches Xpos)
YW, 10, Y coordinate width (matches Ypos)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request a new line; sampled only in IDLE
x0  in  XW  start X
y0  in  YW  start Y
x1  in  XW  end X
y1  in  YW  end Y
pix_ready  in  1  downstream accepts current pixel when plot and pix_ready are both high
busy  out  1  high from the cycle after start is accepted until done
plot  out  1  current x,y is a valid pixel
x  out  XW  current pixel X
y  out  YW  current pixel Y
pix_count  out  XW  pixels accepted so far in the current line
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, plot=0, done=0, x=0, y=0, pix_count=0; internal err=0.
- Reset mid-line: aborts immediately. No done pulse. Next start after reset release is served normally.
- State machine: IDLE -> INIT -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge N: latch x0,y0,x1,y1; x<=x0, y<=y0; busy<=1; pix_count<=0; go to INIT.
  - start=0: remain in IDLE.
- INIT (one cycle):
  - dx=|x1-x0|, unsigned XW bits.
  - dy=-|y1-y0|, signed.
  - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
  - err<=dx+dy.
  - Go to RUN with plot<=1. First pixel is valid from cycle N+2.
- RUN:
  - plot=1 and x,y are held stable until the pixel is accepted (plot && pix_ready).
  - On accept, pix_count increments.
  - If x==x1 and y==y1 at accept: plot<=0, go to DONE.
  - Otherwise, with e2=2*err: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy. Both steps may apply in the same cycle (diagonal move).
- DONE (one cycle): done=1, busy<=0, go to IDLE. done and plot are never high together.
- Arithmetic: err and e2 are signed 14-bit (covers -2046..+4094 without overflow). x and y wrap naturally but never leave the latched endpoint box.
- Pixel count: total accepted pixels = max(dx,|dy|)+1. pix_count holds this final value through DONE and IDLE until the next start.
- Degenerate line (x0==x1, y0==y1): exactly one pixel at (x0,y0), then done.
- Input stability: start while busy, INIT, RUN or DONE is ignored. Endpoint inputs may change after acceptance without effect.
- Back-to-back lines: a start coincident with the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted, giving a minimum 2-cycle gap between lines.
- Throughput: one pixel per cycle while pix_ready=1.

Test Plan:
1. Horizontal line, start with (100,100)->(200,100), pix_ready=1 -> 101 plots, x=100..200 in order, y=100 throughout; done pulses exactly once, one cycle after the (200,100) accept; pix_count=101.
2. Steep edge (200,100)->(230,150) -> 51 plots; y steps +1 on every pixel; x steps on 30 of them; last pixel (230,150); pix_count=51.
3. Reverse octant (100,200)->(70,150) -> sx=-1, sy=-1; 51 plots; first pixel (100,200), last pixel (70,150); x and y never increase.
4. Degenerate (5,5)->(5,5) -> exactly one plot cycle at (5,5), done the next cycle, pix_count=1.
5. Backpressure on scenario 1 with pix_ready toggling 1,0,1,0 -> identical 101-pixel sequence; x,y held constant while pix_ready=0; duration about 201 cycles; a single done.
6. Control robustness:
   - start pulsed during RUN -> ignored; the line completes unchanged.
   - reset asserted during pixel 40 of scenario 1 -> busy=plot=done=0 and x=y=0 immediately, no done; a fresh start of (0,0)->(3,0) then yields 4 plots.

Source files
------------

// File: rtl/cube_line_raster.sv
// cube_line_raster: Bresenham edge walker emitting one pixel per accepted cycle
module cube_line_raster #(
   parameter int XW = 11,
   parameter int YW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [XW-1:0] x0,
   input  logic [YW-1:0] y0,
   input  logic [XW-1:0] x1,
   input  logic [YW-1:0] y1,
   input  logic          pix_ready,
   output logic          busy,
   output logic          plot,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [XW-1:0] pix_count,
   output logic          done
);
   localparam int EW = 14;
   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
   state_t               state_q;
   logic [XW-1:0]        x_q, x1_q, dx_q, cnt_q;
   logic [YW-1:0]        y_q, y1_q;
   logic signed [EW-1:0] dy_q, err_q;
   logic                 sx_q, sy_q, busy_q, plot_q, done_q;
   logic [XW-1:0]        dx_d;
   logic [YW-1:0]        ady_d;
   logic signed [EW-1:0] dxs, e2, err_d, err0_d, dy_d;
   logic                 step_x, step_y, acc, last;
   // x_q/y_q still hold the start point during INIT, so deltas come from them
   always_comb begin
      dx_d   = (x1_q >= x_q) ? x1_q - x_q : x_q - x1_q;
      ady_d  = (y1_q >= y_q) ? y1_q - y_q : y_q - y1_q;
      dy_d   = -$signed({{(EW-YW){1'b0}}, ady_d});
      err0_d = $signed({{(EW-XW){1'b0}}, dx_d}) + dy_d;
      dxs    = $signed({{(EW-XW){1'b0}}, dx_q});
      e2     = err_q <<< 1;
      step_x = e2 >= dy_q;
      step_y = e2 <= dxs;
      err_d  = err_q + (step_x ? dy_q : '0) + (step_y ? dxs : '0);
      acc    = plot_q && pix_ready;
      last   = (x_q == x1_q) && (y_q == y1_q);
   end
   // line FSM with registered outputs; pixel state only advances on accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         plot_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               x_q     <= x0;
               y_q     <= y0;
               x1_q    <= x1;
               y1_q    <= y1;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= INIT;
            end
            INIT: begin
               dx_q    <= dx_d;
               dy_q    <= dy_d;
               err_q   <= err0_d;
               sx_q    <= !(x_q < x1_q);
               sy_q    <= !(y_q < y1_q);
               plot_q  <= 1'b1;
               state_q <= RUN;
            end
            RUN: if (acc) begin
               cnt_q <= cnt_q + XW'(1);
               if (last) begin
                  plot_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  err_q <= err_d;
                  if (step_x) x_q <= sx_q ? x_q - XW'(1) : x_q + XW'(1);
                  if (step_y) y_q <= sy_q ? y_q - YW'(1) : y_q + YW'(1);
               end
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
   assign busy      = busy_q;
   assign plot      = plot_q;
   assign done      = done_q;
   assign x         = x_q;
   assign y         = y_q;
   assign pix_count = cnt_q;
endmodule
